mult_result_collector: RTL and testbench
========================================

MULT_RESULT_COLLECTOR -- requirements
Module: mult_result_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 4: result FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter SUM_W, default 24: running-sum width (>=17).
REQ-003 SHALL have port clk, input, 1: single clock, shared with the upstream multiplier.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset, the same net that resets the multiplier.
REQ-005 SHALL have port prod_in, input, 16: multiplier out bus.
REQ-006 SHALL have port sum_clr, input, 1: synchronous clear of acc_sum/acc_sat.
REQ-007 SHALL have port res_ready, input, 1: downstream ready.
REQ-008 SHALL have port res_valid, output, 1: FIFO head valid.
REQ-009 SHALL have port res_data, output, 16: FIFO head product.
REQ-010 SHALL have port res_tag, output, 4: FIFO head sequence tag.
REQ-011 SHALL have port acc_sum, output, SUM_W: saturating sum of accepted products.
REQ-012 SHALL have port acc_sat, output, 1: sticky saturation flag.
REQ-013 SHALL have port drop_flag, output, 1: sticky "product lost, FIFO full" flag.
REQ-014 SHALL have port level, output, clog2(DEPTH)+1: FIFO occupancy.

Function
REQ-015 SHALL keep a 4-bit phase counter mirroring the multiplier stage: 0 after reset, +1 per cycle, 9 -> 0 wrap; values 10-15 unreachable.
REQ-016 SHALL treat the cycle with phase==9 as the capture cycle: prod_in then equals the product of the operands sampled at phase 0, nine cycles earlier.
REQ-017 SHALL assign each capture event the current 4-bit tag, then increment the tag (mod 16), whether or not the product is stored.
REQ-018 SHALL push {prod_in, tag} at the capture-cycle edge if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
REQ-019 SHALL, when capturing with the FIFO full and no pop, discard the product, set drop_flag, and leave the FIFO and acc_sum unchanged.
REQ-020 SHALL pop on res_valid && res_ready; res_valid = (level!=0); res_data/res_tag = head entry, stable while res_valid && !res_ready.
REQ-021 SHALL assert res_valid in the cycle after a push into an empty FIFO (1-cycle latency, no combinational path from prod_in to outputs).
REQ-022 SHALL keep level unchanged on a simultaneous push and pop.
REQ-023 SHALL add each stored product (zero-extended) to acc_sum; if the true sum exceeds 2^SUM_W-1, acc_sum = 2^SUM_W-1 and acc_sat = 1.
REQ-024 SHALL, on sum_clr, zero acc_sum and acc_sat; on sum_clr coincident with a stored capture, acc_sum = prod_in and acc_sat = 0.
REQ-025 SHALL not clear drop_flag except by rst.
REQ-026 SHALL ignore prod_in outside capture cycles.

Reset
REQ-027 SHALL, on rst assertion, asynchronously set phase=0, tag=0, level=0, res_valid=0, res_data=0, res_tag=0, acc_sum=0, acc_sat=0, drop_flag=0.
REQ-028 SHALL, on rst mid-operation (any phase, any level), discard FIFO contents and restart phase at 0 on the first edge after release, in lockstep with the multiplier.
REQ-029 SHALL ignore sum_clr and res_ready while rst is high.

Verification
REQ-030 SHALL verify: rst release, multiplier sees 3x5 at phase 0, res_ready=1 -> res_valid high in the cycle after phase 9, res_data=15, res_tag=0, acc_sum=15.
REQ-031 SHALL verify: res_ready=0, five products 1..5 -> level=4, drop_flag=1, FIFO holds tags 0-3 with data 1-4, acc_sum=10; the next capture after draining carries tag 5.
REQ-032 SHALL verify: FIFO full, res_ready=1 during a capture cycle -> push and pop both occur, level stays 4, drop_flag stays 0.
REQ-033 SHALL verify: 255x255 repeated with res_ready=1 -> acc_sum=16776450, acc_sat=0 after 258 products; acc_sum=16777215, acc_sat=1 after 259.
REQ-034 SHALL verify: sum_clr on a capture of 7x9 -> acc_sum=63, acc_sat=0.
REQ-035 SHALL verify: rst pulse at phase 5 with level=2 -> outputs zero immediately; the first capture after release occurs 10 cycles later with tag 0.

Source files
------------

// File: rtl/mult_result_collector.sv
// Collects products from a 10-phase multiplier, queues them with sequence tags,
// and keeps a saturating running sum of every product that gets stored.
module mult_result_collector #(
    parameter int DEPTH = 4,
    parameter int SUM_W = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              prod_in,
    input  logic                     sum_clr,
    input  logic                     res_ready,
    output logic                     res_valid,
    output logic [15:0]              res_data,
    output logic [3:0]               res_tag,
    output logic [SUM_W-1:0]         acc_sum,
    output logic                     acc_sat,
    output logic                     drop_flag,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [3:0]    phase;
    logic [3:0]    tag;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [19:0]   fifo_mem [DEPTH];
    logic          capture;
    logic          pop;
    logic          push;
    logic [SUM_W:0] sum_nxt;

    // Returns {overflowed, clamped_sum}; the extra bit cannot wrap because SUM_W >= 17.
    function automatic logic [SUM_W:0] add_sat(input logic [SUM_W-1:0] a, input logic [15:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + (SUM_W + 1)'(b);
        if (s[SUM_W])
            return {1'b1, {SUM_W{1'b1}}};
        return s;
    endfunction

    assign capture   = (phase == 4'd9);
    assign res_valid = (level != '0);
    assign pop       = res_valid && res_ready;
    assign push      = capture && ((level != LW'(DEPTH)) || pop);
    assign sum_nxt   = add_sat(acc_sum, prod_in);

    // Head is gated so an empty or freshly reset FIFO presents zeros.
    assign res_data  = res_valid ? fifo_mem[rd_ptr][19:4] : '0;
    assign res_tag   = res_valid ? fifo_mem[rd_ptr][3:0]  : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= '0;
            tag       <= '0;
            drop_flag <= 1'b0;
        end else begin
            phase <= capture ? 4'd0 : phase + 4'd1;
            if (capture) begin
                tag <= tag + 4'd1;
                if (!push)
                    drop_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {prod_in, tag};
    end

    // A clear that coincides with a stored capture restarts the sum from that product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_sum <= '0;
            acc_sat <= 1'b0;
        end else if (sum_clr) begin
            acc_sum <= push ? SUM_W'(prod_in) : '0;
            acc_sat <= 1'b0;
        end else if (push) begin
            acc_sum <= sum_nxt[SUM_W-1:0];
            if (sum_nxt[SUM_W])
                acc_sat <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_result_collector.sv
// Directed and random checks of mult_result_collector against a queue-based reference.
module tb_mult_result_collector;

    localparam int DEPTH = 4;
    localparam int SUM_W = 24;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam longint SMAX = (64'd1 << SUM_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [15:0]       prod_in = '0;
    logic              sum_clr = 1'b0;
    logic              res_ready = 1'b0;
    logic              res_valid;
    logic [15:0]       res_data;
    logic [3:0]        res_tag;
    logic [SUM_W-1:0]  acc_sum;
    logic              acc_sat;
    logic              drop_flag;
    logic [LW-1:0]     level;

    mult_result_collector #(.DEPTH(DEPTH), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst), .prod_in(prod_in), .sum_clr(sum_clr),
        .res_ready(res_ready), .res_valid(res_valid), .res_data(res_data),
        .res_tag(res_tag), .acc_sum(acc_sum), .acc_sat(acc_sat),
        .drop_flag(drop_flag), .level(level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  t;
    } ent_t;

    ent_t   q[$];
    longint m_sum;
    bit     m_sat;
    bit     m_drop;
    int     m_tag;
    int     m_ph;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", name, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("res_valid", res_valid, q.size() > 0);
        chk("res_data",  res_data,  (q.size() > 0) ? q[0].d : 16'd0);
        chk("res_tag",   res_tag,   (q.size() > 0) ? q[0].t : 4'd0);
        chk("level",     level,     q.size());
        chk("acc_sum",   acc_sum,   m_sum);
        chk("acc_sat",   acc_sat,   m_sat);
        chk("drop_flag", drop_flag, m_drop);
    endtask

    task automatic model_reset();
        q.delete();
        m_sum = 0; m_sat = 0; m_drop = 0; m_tag = 0; m_ph = 0;
    endtask

    // One clock of the reference, using the inputs as they stood at the edge.
    task automatic model_step();
        bit pop, cap, store;
        pop   = (q.size() > 0) && res_ready;
        cap   = (m_ph == 9);
        store = 0;
        if (cap) begin
            store = (q.size() < DEPTH) || pop;
            if (!store) m_drop = 1;
        end
        if (pop) void'(q.pop_front());
        if (store) q.push_back({prod_in, 4'(m_tag)});
        if (cap) m_tag = (m_tag + 1) % 16;
        if (sum_clr) begin
            m_sum = store ? longint'(prod_in) : 0;
            m_sat = 0;
        end else if (store) begin
            m_sum += prod_in;
            if (m_sum > SMAX) begin
                m_sum = SMAX;
                m_sat = 1;
            end
        end
        m_ph = (m_ph + 1) % 10;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic run_cycle(input logic [15:0] cap_val, input logic rdy, input logic clr_at_cap);
        prod_in   = (m_ph == 9) ? cap_val : 16'($urandom);
        res_ready = rdy;
        sum_clr   = clr_at_cap && (m_ph == 9);
        tick();
    endtask

    task automatic run_period(input logic [15:0] cap_val, input logic rdy, input logic clr_at_cap);
        repeat (10) run_cycle(cap_val, rdy, clr_at_cap);
    endtask

    // Reset also drives sum_clr/res_ready high to show they are ignored.
    task automatic do_reset();
        rst = 1'b1; sum_clr = 1'b1; res_ready = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1; check_all();
        @(posedge clk); #1; check_all();
        rst = 1'b0; sum_clr = 1'b0; res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // First product after reset: 3x5
        do_reset();
        run_period(16'd15, 1'b1, 1'b0);
        chk("t1_valid", res_valid, 1);
        chk("t1_data",  res_data, 15);
        chk("t1_tag",   res_tag, 0);
        chk("t1_sum",   acc_sum, 15);

        // Overflow with downstream stalled, then drain
        do_reset();
        for (int i = 1; i <= 5; i++) run_period(16'(i), 1'b0, 1'b0);
        chk("t2_level", level, 4);
        chk("t2_drop",  drop_flag, 1);
        chk("t2_sum",   acc_sum, 10);
        for (int i = 0; i < 4; i++) begin
            chk("t2_head_tag",  res_tag, i);
            chk("t2_head_data", res_data, i + 1);
            run_cycle(16'd6, 1'b1, 1'b0);
        end
        while (m_ph != 0) run_cycle(16'd6, 1'b1, 1'b0);
        chk("t2_next_tag",  res_tag, 5);
        chk("t2_next_data", res_data, 6);
        chk("t2_drop_kept", drop_flag, 1);

        // Full FIFO with a pop in the capture cycle
        do_reset();
        for (int i = 1; i <= 4; i++) run_period(16'(i), 1'b0, 1'b0);
        repeat (9) run_cycle(16'd9, 1'b0, 1'b0);
        run_cycle(16'd9, 1'b1, 1'b0);
        chk("t3_level", level, 4);
        chk("t3_drop",  drop_flag, 0);
        chk("t3_head",  res_tag, 1);
        chk("t3_sum",   acc_sum, 19);

        // Saturation with 255x255
        do_reset();
        repeat (258) run_period(16'd65025, 1'b1, 1'b0);
        chk("t4_sum_258", acc_sum, 16776450);
        chk("t4_sat_258", acc_sat, 0);
        run_period(16'd65025, 1'b1, 1'b0);
        chk("t4_sum_259", acc_sum, 16777215);
        chk("t4_sat_259", acc_sat, 1);
        run_period(16'd65025, 1'b1, 1'b0);

        // Clear coincident with a capture of 7x9, then a clear on its own
        run_period(16'd63, 1'b1, 1'b1);
        chk("t5_sum", acc_sum, 63);
        chk("t5_sat", acc_sat, 0);
        prod_in = 16'($urandom); sum_clr = 1'b1; res_ready = 1'b1;
        tick();
        chk("t5_clr_only", acc_sum, 0);
        while (m_ph != 0) run_cycle(16'd1, 1'b1, 1'b0);

        // Reset at phase 5 with two entries queued
        do_reset();
        run_period(16'd11, 1'b0, 1'b0);
        run_period(16'd12, 1'b0, 1'b0);
        repeat (5) run_cycle(16'd13, 1'b0, 1'b0);
        chk("t6_level_pre", level, 2);
        do_reset();
        n = 0;
        while (!res_valid && n < 20) begin
            run_cycle(16'd21, 1'b1, 1'b0);
            n++;
        end
        chk("t6_latency", n, 10);
        chk("t6_tag",  res_tag, 0);
        chk("t6_data", res_data, 21);
        while (m_ph != 0) run_cycle(16'd1, 1'b1, 1'b0);

        // Randomized traffic
        do_reset();
        repeat (800) begin
            prod_in   = 16'($urandom);
            res_ready = ($urandom_range(0, 9) < 3);
            sum_clr   = ($urandom_range(0, 30) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
